// File: rtl/mips_pkg.sv
// Shared MIPS memory-stage types: access-size encodings, memory FSM states, alignment helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mips_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } mem_state_t;

    // True when the low address bits are not a multiple of the access size.
    // Encoding 2'b11 is handled like a word.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] alo);
        logic r;
        case (size)
            SZ_BYTE: r = 1'b0;
            SZ_HALF: r = alo[0];
            default: r = (alo != 2'b00);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for sub-word accesses: byte enables, replicated store data, extended load value.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the caller decides when outputs are used.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  alo,
    input  logic        sgn,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_out,
    output logic [31:0] load_val
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select lanes by size; low bits below the access size are simply not looked at,
    // which is what makes unaligned addresses behave as aligned ones.
    always_comb begin
        be        = 4'b1111;
        wdata_out = wdata_in;
        load_val  = rdata;
        byte_lane = rdata[{alo, 3'b000} +: 8];
        half_lane = alo[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << alo;
                wdata_out = {4{wdata_in[7:0]}};
                load_val  = sgn ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            end
            SZ_HALF: begin
                be        = alo[1] ? 4'b1100 : 4'b0011;
                wdata_out = {2{wdata_in[15:0]}};
                load_val  = sgn ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            end
            default: begin
                be        = 4'b1111;
                wdata_out = wdata_in;
                load_val  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MIPS memory stage: issues loads/stores to a variable-latency port, one result per op to WB.
// Latency: non-memory ops 1 cycle; memory ops 1 + REQ cycles until mem_ack (or timeout).
// Backpressure: stall held high while a memory op is accepted or in flight. Option: MISALIGN_CHECK_EN.
module mem_access
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemSigned,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] WbData,
    output logic        wb_valid,
    output logic        bus_err
);

    mem_state_t      state, state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic            lat_rd;
    logic            lat_sgn;
    logic [1:0]      lat_size;
    logic [1:0]      lat_alo;

    logic            mem_op, accept, misalign, issue, done, timeout;
    logic [1:0]      sel_size, sel_alo;
    logic [3:0]      lane_be;
    logic [31:0]     lane_wdata, load_val;

    assign mem_op = MemRead | MemWrite;
    assign accept = (state == IDLE) & ex_valid;
`ifdef MISALIGN_CHECK_EN
    assign misalign = is_misaligned(MemSize, ALUResult[1:0]);
`else
    assign misalign = 1'b0;
`endif
    assign issue   = accept & mem_op & ~misalign;
    assign done    = (state == REQ) & mem_ack;
    assign timeout = (state == REQ) & ~mem_ack & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    assign stall   = (state != IDLE) | (ex_valid & mem_op);
    // Derived from state so an async reset drops the request in the same cycle.
    assign mem_req = (state == REQ);

    // Live inputs steer the store lanes at issue; latched ones extract the load at ack.
    assign sel_size = (state == IDLE) ? MemSize        : lat_size;
    assign sel_alo  = (state == IDLE) ? ALUResult[1:0] : lat_alo;

    mem_lane_align u_lane (
        .size      (sel_size),
        .alo       (sel_alo),
        .sgn       (lat_sgn),
        .wdata_in  (WriteData),
        .rdata     (mem_rdata),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .load_val  (load_val)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: IDLE -> REQ on an issued access, back on ack or timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (issue)           state_nxt = REQ;
            REQ:     if (done | timeout)  state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Timeout counter: restarts at issue, advances on each REQ cycle without ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    to_cnt <= '0;
        else if (issue)                                to_cnt <= '0;
        else if ((state == REQ) && !mem_ack && !timeout) to_cnt <= to_cnt + TO_W'(1);
    end

    // Request latch, write-back data and the one-cycle result/error pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            WbData    <= '0;
            wb_valid  <= 1'b0;
            bus_err   <= 1'b0;
            lat_rd    <= 1'b0;
            lat_sgn   <= 1'b0;
            lat_size  <= SZ_BYTE;
            lat_alo   <= 2'b00;
        end else begin
            wb_valid <= 1'b0;
            bus_err  <= 1'b0;
            if (accept && !mem_op) begin
                WbData   <= ALUResult;
                wb_valid <= 1'b1;
            end else if (accept && misalign) begin
                WbData   <= '0;
                wb_valid <= 1'b1;
                bus_err  <= 1'b1;
            end else if (issue) begin
                mem_we    <= ~MemRead & MemWrite;
                mem_addr  <= {ALUResult[31:2], 2'b00};
                mem_be    <= lane_be;
                mem_wdata <= lane_wdata;
                lat_rd    <= MemRead;
                lat_sgn   <= MemSigned;
                lat_size  <= MemSize;
                lat_alo   <= ALUResult[1:0];
            end else if (done) begin
                WbData   <= lat_rd ? load_val : 32'h0;
                wb_valid <= 1'b1;
            end else if (timeout) begin
                WbData   <= '0;
                wb_valid <= 1'b1;
                bus_err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: lanes, extension, wait states, timeout, reset, misalignment.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [31:0] ALUResult, WriteData;
    logic        MemRead, MemWrite;
    logic [1:0]  MemSize;
    logic        MemSigned;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata, WbData;
    logic        wb_valid, bus_err;

    int n_cmp = 0;
    int n_err = 0;

    mem_access #(.TIMEOUT_CYCLES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemSize   (MemSize),
        .MemSigned (MemSigned),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .WbData    (WbData),
        .wb_valid  (wb_valid),
        .bus_err   (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents one op in an IDLE cycle; returns at the negedge of the following cycle.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                         input logic exp_stall);
        @(negedge clk);
        ex_valid = 1'b1; MemRead = rd; MemWrite = wr; ALUResult = addr;
        WriteData = wd; MemSize = sz; MemSigned = sg;
        #1;
        chk("stall_at_issue", 32'(stall), 32'(exp_stall));
        @(negedge clk);
        ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        ALUResult = 32'hDEAD_0000; WriteData = 32'h5555_5555;
    endtask

    // Serves n REQ cycles, acking in the last; returns in the cycle after the ack.
    task automatic serve(input int n, input logic [31:0] rdata,
                         output int stall_cyc, output logic stable);
        logic [31:0] a0;
        logic [3:0]  b0;
        a0 = mem_addr; b0 = mem_be; stall_cyc = 0; stable = 1'b1;
        for (int k = 1; k <= n; k++) begin
            if (stall) stall_cyc++;
            if (!mem_req || mem_addr != a0 || mem_be != b0) stable = 1'b0;
            mem_rdata = rdata;
            mem_ack   = (k == n);
            @(negedge clk);
        end
        mem_ack = 1'b0;
    endtask

    int   sc, n;
    logic st;

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; ALUResult = '0; WriteData = '0;
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSigned = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wbdata", WbData, 0);
        rst_n = 1'b1;

        // Plain ALU op, latency 1.
        issue(1'b0, 1'b0, 32'h1357_9BDF, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("alu_wb_valid", 32'(wb_valid), 1);
        chk("alu_wbdata", WbData, 32'h1357_9BDF);
        @(negedge clk);
        chk("alu_wb_pulse", 32'(wb_valid), 0);

        // Store byte at 0x13, ack in the first REQ cycle.
        issue(1'b0, 1'b1, 32'h13, 32'hAB, 2'b00, 1'b0, 1'b1);
        chk("sb_req", 32'(mem_req), 1);
        chk("sb_we", 32'(mem_we), 1);
        chk("sb_addr", mem_addr, 32'h10);
        chk("sb_be", 32'(mem_be), 32'h8);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        chk("sb_no_early_wb", 32'(wb_valid), 0);
        serve(1, 32'h0, sc, st);
        chk("sb_wb_valid", 32'(wb_valid), 1);
        chk("sb_wbdata", WbData, 0);
        chk("sb_req_drop", 32'(mem_req), 0);

        // Load half signed / unsigned at 0x102.
        issue(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b1, 1'b1);
        chk("lhs_be", 32'(mem_be), 32'hC);
        chk("lhs_addr", mem_addr, 32'h100);
        chk("lhs_we", 32'(mem_we), 0);
        serve(1, 32'h8001_1234, sc, st);
        chk("lhs_wbdata", WbData, 32'hFFFF_8001);
        issue(1'b1, 1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 1'b1);
        serve(1, 32'h8001_1234, sc, st);
        chk("lhu_wbdata", WbData, 32'h0000_8001);

        // Store half to the lower half, load byte signed from lane 1.
        issue(1'b0, 1'b1, 32'h24, 32'h1234_BEEF, 2'b01, 1'b0, 1'b1);
        chk("sh_be", 32'(mem_be), 32'h3);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        serve(1, 32'h0, sc, st);
        issue(1'b1, 1'b0, 32'h101, 32'h0, 2'b00, 1'b1, 1'b1);
        chk("lb_be", 32'(mem_be), 32'h2);
        serve(1, 32'h0000_8000, sc, st);
        chk("lb_wbdata", WbData, 32'hFFFF_FF80);

        // Word load with ack in the third REQ cycle.
        issue(1'b1, 1'b0, 32'h200, 32'h0, 2'b10, 1'b0, 1'b1);
        chk("lw_addr", mem_addr, 32'h200);
        chk("lw_be", 32'(mem_be), 32'hF);
        serve(3, 32'hDEAD_BEEF, sc, st);
        chk("lw_stall_cycles", 32'(sc + 1), 4);
        chk("lw_req_stable", 32'(st), 1);
        chk("lw_wb_valid", 32'(wb_valid), 1);
        chk("lw_wbdata", WbData, 32'hDEAD_BEEF);
        chk("lw_stall_released", 32'(stall), 0);

        // No ack: times out after 16 REQ cycles.
        issue(1'b1, 1'b0, 32'h300, 32'h0, 2'b10, 1'b0, 1'b1);
        n = 0;
        for (int k = 0; k < 40 && mem_req; k++) begin
            n++;
            @(negedge clk);
        end
        chk("to_req_cycles", 32'(n), 16);
        chk("to_wb_valid", 32'(wb_valid), 1);
        chk("to_bus_err", 32'(bus_err), 1);
        chk("to_wbdata", WbData, 0);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_wb", 32'(wb_valid), 0);
        chk("late_ack_req", 32'(mem_req), 0);

        // Word load at 0x102.
`ifdef MISALIGN_CHECK_EN
        issue(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 1'b1);
        chk("mis_no_req", 32'(mem_req), 0);
        chk("mis_bus_err", 32'(bus_err), 1);
        chk("mis_wb_valid", 32'(wb_valid), 1);
        chk("mis_wbdata", WbData, 0);
        chk("mis_stall", 32'(stall), 0);
`else
        issue(1'b1, 1'b0, 32'h102, 32'h0, 2'b10, 1'b0, 1'b1);
        chk("unal_addr", mem_addr, 32'h100);
        chk("unal_be", 32'(mem_be), 32'hF);
        serve(1, 32'hCAFE_F00D, sc, st);
        chk("unal_wbdata", WbData, 32'hCAFE_F00D);
        chk("unal_no_err", 32'(bus_err), 0);
`endif

        // Reset during REQ drops mem_req immediately, no result afterwards.
        issue(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 1'b1);
        chk("rreq_req_before", 32'(mem_req), 1);
        rst_n = 1'b0;
        #1;
        chk("rreq_req_drop", 32'(mem_req), 0);
        chk("rreq_stall_drop", 32'(stall), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rreq_no_wb", 32'(wb_valid), 0);
        issue(1'b0, 1'b0, 32'h0BAD_CAFE, 32'h0, 2'b10, 1'b0, 1'b0);
        chk("post_rst_wb_valid", 32'(wb_valid), 1);
        chk("post_rst_wbdata", WbData, 32'h0BAD_CAFE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
